// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a single-port on-chip SRAM, one transaction at a time, IDs echoed.
// Latency: first R beat one cycle after AR handshake, back-to-back beats after; B two cycles after AW when W is ready.
// Backpressure: W stalls until AW is taken, R holds data while rready is low, B holds until bready.
// Optional: define AXI4_SRAM_SLAVE_DECERR_EN to answer out-of-range addresses with DECERR instead of aliasing.
module axi4_sram_slave #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int IDW        = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [IDW-1:0]    s_axi_awid,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [IDW-1:0]    s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [IDW-1:0]    s_axi_arid,
  input  logic [AW-1:0]     s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [IDW-1:0]    s_axi_rid,
  output logic [DW-1:0]     s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  state_t          state_q;
  logic            prio_rd_q;
  logic [IDW-1:0]  id_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      cnt_q;
  logic            fixed_q;
  logic            slverr_q;
  logic            dec_q;
  logic            wready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic            rlast_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;

  logic [DW-1:0]   mem [0:(1<<IW)-1];

  logic            idle;
  logic            aw_go;
  logic            ar_go;
  logic            w_fire;
  logic            r_fire;
  logic [IW-1:0]   aw_idx;
  logic [IW-1:0]   ar_idx;
  logic [IW-1:0]   ar_step;
  logic [IW-1:0]   idx_step;
  logic [IW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic            mem_we;
  logic            aw_oor;
  logic            ar_oor;
  logic            slverr_d;
  logic            unused_ok;

  // Arbitration is combinational so the losing channel sees ready low in the very cycle both are valid.
  assign idle          = (state_q == S_IDLE) && !wb_rst_i;
  assign s_axi_awready = idle && !(s_axi_arvalid && prio_rd_q);
  assign s_axi_arready = idle && !(s_axi_awvalid && !prio_rd_q);
  assign aw_go         = s_axi_awready && s_axi_awvalid;
  assign ar_go         = s_axi_arready && s_axi_arvalid;
  assign w_fire        = wready_q && s_axi_wvalid;
  assign r_fire        = rvalid_q && s_axi_rready;

  assign aw_idx   = s_axi_awaddr[IW+OFF-1:OFF];
  assign ar_idx   = s_axi_araddr[IW+OFF-1:OFF];
  assign ar_step  = IW'(s_axi_arburst != 2'b00);
  assign idx_step = IW'(!fixed_q);

`ifdef AXI4_SRAM_SLAVE_DECERR_EN
  assign aw_oor = |(s_axi_awaddr >> (IW + OFF));
  assign ar_oor = |(s_axi_araddr >> (IW + OFF));
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Size and sub-word address bits carry no meaning here: every beat is full width.
  assign unused_ok = ^{s_axi_awsize, s_axi_awaddr, s_axi_araddr};

  // A wlast that disagrees with the awlen beat count poisons the response but never shortens the burst.
  assign slverr_d = slverr_q || (s_axi_wlast != (cnt_q == 8'd0));

  // One address port serves both directions: the AR index while idle, the running burst index otherwise.
  assign mem_addr  = (state_q == S_IDLE) ? ar_idx : idx_q;
  assign mem_rdata = mem[mem_addr];
  assign mem_we    = w_fire && !dec_q;

  // SRAM array with byte-lane write enables; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[mem_addr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Transaction FSM with all response-channel outputs registered.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      prio_rd_q <= 1'b0;
      id_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      slverr_q  <= 1'b0;
      dec_q     <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (aw_go) begin
            prio_rd_q <= !prio_rd_q;
            id_q      <= s_axi_awid;
            idx_q     <= aw_idx;
            cnt_q     <= s_axi_awlen;
            fixed_q   <= (s_axi_awburst == 2'b00);
            slverr_q  <= 1'b0;
            dec_q     <= aw_oor;
            wready_q  <= 1'b1;
            state_q   <= S_WDATA;
          end else if (ar_go) begin
            prio_rd_q <= !prio_rd_q;
            id_q      <= s_axi_arid;
            idx_q     <= ar_idx + ar_step;
            cnt_q     <= s_axi_arlen;
            fixed_q   <= (s_axi_arburst == 2'b00);
            dec_q     <= ar_oor;
            rvalid_q  <= 1'b1;
            rlast_q   <= (s_axi_arlen == 8'd0);
            rresp_q   <= ar_oor ? RESP_DECERR : RESP_OKAY;
            rdata_q   <= ar_oor ? '0 : mem_rdata;
            state_q   <= S_RDATA;
          end
        end
        S_WDATA: begin
          if (w_fire) begin
            idx_q    <= idx_q + idx_step;
            cnt_q    <= cnt_q - 8'd1;
            slverr_q <= slverr_d;
            if (cnt_q == 8'd0) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= dec_q ? RESP_DECERR : (slverr_d ? RESP_SLVERR : RESP_OKAY);
              state_q  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (bvalid_q && s_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (r_fire) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              rdata_q <= dec_q ? '0 : mem_rdata;
              idx_q   <= idx_q + idx_step;
              cnt_q   <= cnt_q - 8'd1;
              rlast_q <= (cnt_q == 8'd1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_axi_wready = wready_q;
  assign s_axi_bid    = id_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_rid    = id_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rvalid = rvalid_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: single beats, strobes, bursts with stalls, wlast errors,
// arbitration, reset mid-burst and (when AXI4_SRAM_SLAVE_DECERR_EN is defined) decode errors.
module tb_axi4_sram_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IDW = 4;
  localparam int DEPTH_LOG2 = 10;

  logic clk = 1'b0;
  logic rst;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  axi4_sram_slave #(.DW(DW), .AW(AW), .IDW(IDW), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every task starts and ends one time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = awready;
      tick();
    end
    awvalid = 1'b0;
    chk("aw_handshake", ok, 1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = arready;
      tick();
    end
    arvalid = 1'b0;
    chk("ar_handshake", ok, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok;
    ok = 1'b0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = wready;
      tick();
    end
    wvalid = 1'b0;
    chk("w_handshake", ok, 1);
  endtask

  task automatic recv_b(input logic [3:0] id, input logic [1:0] resp);
    bit ok;
    ok = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if (bvalid) begin
        ok = 1'b1;
        chk("bid", bid, id);
        chk("bresp", bresp, resp);
        chk("b_no_r_overlap", rvalid, 0);
      end
      tick();
    end
    bready = 1'b0;
    chk("b_arrived", ok, 1);
  endtask

  task automatic recv_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    bit ok;
    ok = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if (rvalid) begin
        ok = 1'b1;
        chk("rid", rid, id);
        chk("rdata", rdata, data);
        chk("rresp", rresp, resp);
        chk("rlast", rlast, last);
        chk("r_no_b_overlap", bvalid, 0);
      end
      tick();
    end
    rready = 1'b0;
    chk("r_arrived", ok, 1);
  endtask

  task automatic write1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp);
    send_aw(id, addr, 8'd0, 2'b01);
    send_w(data, strb, 1'b1);
    recv_b(id, resp);
  endtask

  task automatic read1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] resp);
    send_ar(id, addr, 8'd0, 2'b01);
    recv_r(id, data, resp, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] burst_dat [4];
    int beat;

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    tick(); tick();

    // Reset state: every output low
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    // 1: AW and W presented together, B two edges after AW, then read back in two cycles
    awid = 4'h3; awaddr = 32'h10; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    chk("t1_awready", awready, 1);
    chk("t1_wready_idle", wready, 0);
    tick();
    awvalid = 1'b0;
    chk("t1_wready", wready, 1);
    tick();
    wvalid = 1'b0;
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bid", bid, 4'h3);
    chk("t1_bresp", bresp, 2'b00);
    tick();
    bready = 1'b0;
    chk("t1_bvalid_clr", bvalid, 0);
    arid = 4'h4; araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
    #1;
    chk("t1_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("t1_rvalid", rvalid, 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_rlast", rlast, 1);
    chk("t1_rid", rid, 4'h4);
    tick();
    rready = 1'b0;
    chk("t1_rvalid_clr", rvalid, 0);

    // 2: partial strobe merge
    write1(4'h1, 32'h20, 32'h11223344, 4'hF, 2'b00);
    write1(4'h2, 32'h20, 32'hAABBCCDD, 4'h5, 2'b00);
    read1(4'h2, 32'h20, 32'h11BB33DD, 2'b00);

    // 3: INCR burst write then read with rready toggling
    send_aw(4'h5, 32'h0, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      burst_dat[i] = 32'hC0DE0000 + i;
      send_w(burst_dat[i], 4'hF, i == 3);
    end
    recv_b(4'h5, 2'b00);
    send_ar(4'h6, 32'h0, 8'd3, 2'b01);
    beat = 0;
    for (int cyc = 0; cyc < 30 && beat < 4; cyc++) begin
      rready = (cyc % 2 == 0);
      #1;
      if (rvalid) begin
        chk("t3_rdata", rdata, burst_dat[beat]);
        chk("t3_rlast", rlast, beat == 3);
        if (rready) beat++;
      end
      tick();
    end
    rready = 1'b0;
    chk("t3_beats", beat, 4);
    chk("t3_rvalid_end", rvalid, 0);

    // 4: early wlast still takes all beats and reports SLVERR; FIXED keeps the last beat
    send_aw(4'h7, 32'h40, 8'd1, 2'b01);
    send_w(32'hAAAA0001, 4'hF, 1'b1);
    send_w(32'hAAAA0002, 4'hF, 1'b0);
    recv_b(4'h7, 2'b10);
    read1(4'h7, 32'h40, 32'hAAAA0001, 2'b00);
    read1(4'h7, 32'h44, 32'hAAAA0002, 2'b00);
    send_aw(4'h8, 32'h50, 8'd2, 2'b00);
    send_w(32'h00000111, 4'hF, 1'b0);
    send_w(32'h00000222, 4'hF, 1'b0);
    send_w(32'h00000333, 4'hF, 1'b1);
    recv_b(4'h8, 2'b00);
    read1(4'h8, 32'h50, 32'h00000333, 2'b00);

    // 5: contested AW/AR twice from reset: write wins, then read wins
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    awid = 4'h9; awaddr = 32'h60; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'hA; araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("t5_c1_awready", awready, 1);
    chk("t5_c1_arready", arready, 0);
    tick();
    awvalid = 1'b0;
    chk("t5_arready_busy", arready, 0);
    send_w(32'h5A5A5A5A, 4'hF, 1'b1);
    awid = 4'hB; awaddr = 32'h64; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    recv_b(4'h9, 2'b00);
    #1;
    chk("t5_c2_arready", arready, 1);
    chk("t5_c2_awready", awready, 0);
    tick();
    arvalid = 1'b0;
    recv_r(4'hA, 32'hDEADBEEF, 2'b00, 1'b1);
    send_aw(4'hB, 32'h64, 8'd0, 2'b01);
    send_w(32'h0BADF00D, 4'hF, 1'b1);
    recv_b(4'hB, 2'b00);
    read1(4'h1, 32'h60, 32'h5A5A5A5A, 2'b00);
    read1(4'h1, 32'h64, 32'h0BADF00D, 2'b00);

    // 6: out-of-range addressing
`ifdef AXI4_SRAM_SLAVE_DECERR_EN
    read1(4'hC, 32'h80000000, 32'h0, 2'b11);
    write1(4'hC, 32'h80000020, 32'hFFFFFFFF, 4'hF, 2'b11);
    read1(4'hC, 32'h20, 32'h11BB33DD, 2'b00);
`else
    read1(4'hC, 32'h80000010, 32'hDEADBEEF, 2'b00);
    write1(4'hC, 32'h80000070, 32'h12345678, 4'hF, 2'b00);
    read1(4'hC, 32'h70, 32'h12345678, 2'b00);
`endif

    // 6: reset in the middle of a write burst and of a read burst
    send_aw(4'hD, 32'h80, 8'd3, 2'b01);
    send_w(32'h77778888, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_w_wready", wready, 0);
    chk("t6_w_bvalid", bvalid, 0);
    chk("t6_w_awready", awready, 0);
    tick();
    rst = 1'b0;
    tick();
    read1(4'hD, 32'h80, 32'h77778888, 2'b00);
    send_ar(4'hE, 32'h0, 8'd3, 2'b01);
    chk("t6_r_rvalid_pre", rvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_r_rvalid", rvalid, 0);
    chk("t6_r_rlast", rlast, 0);
    chk("t6_r_bvalid", bvalid, 0);
    tick();
    rst = 1'b0;
    tick();
    read1(4'hE, 32'h4, 32'hC0DE0001, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
